// File: rtl/mem_loader.sv
// Byte-stream loader: decodes host frames into instruction/data memory writes and reads,
// plus RUN/HALT control of the core enable. Every output comes straight from a flop.
module mem_loader #(
  parameter int unsigned RD_LAT = 1
) (
  input  logic        clk,
  input  logic        arst_n,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        cpu_enable,
  output logic [63:0] addr_ext,
  output logic        wen_ext,
  output logic        ren_ext,
  output logic [31:0] wdata_ext,
  input  logic [31:0] rdata_ext,
  output logic [63:0] addr_ext_2,
  output logic        wen_ext_2,
  output logic        ren_ext_2,
  output logic [63:0] wdata_ext_2,
  input  logic [63:0] rdata_ext_2,
  output logic        busy,
  output logic        err
);

  localparam logic [7:0] CmdWrI  = 8'h01;
  localparam logic [7:0] CmdWrD  = 8'h02;
  localparam logic [7:0] CmdRdI  = 8'h03;
  localparam logic [7:0] CmdRdD  = 8'h04;
  localparam logic [7:0] CmdRun  = 8'h10;
  localparam logic [7:0] CmdHalt = 8'h11;
  localparam logic [7:0] AckOk   = 8'hA5;
  localparam logic [7:0] AckBad  = 8'hEE;

  localparam logic [1:0] WaitInit = 2'(RD_LAT - 1);

  typedef enum logic [3:0] {
    StCmd, StAddrLo, StAddrHi, StCount, StData, StWrite, StRdReq, StRdWait, StRdSend, StAck
  } state_e;

  state_e      state_q, state_d;
  logic        is_d_q, is_d_d;
  logic        is_rd_q, is_rd_d;
  logic        rej_q, rej_d;
  logic [15:0] addr_q, addr_d;
  logic [8:0]  cnt_q, cnt_d;
  logic [2:0]  byte_idx_q, byte_idx_d;
  logic [63:0] buf_q, buf_d;
  logic [1:0]  wait_q, wait_d;

  logic        rx_ready_q, rx_ready_d;
  logic [7:0]  tx_data_q, tx_data_d;
  logic        tx_valid_q, tx_valid_d;
  logic        cpu_enable_q, cpu_enable_d;
  logic [63:0] addr_ext_q, addr_ext_d;
  logic        wen_q, wen_d;
  logic        ren_q, ren_d;
  logic [31:0] wdata_q, wdata_d;
  logic [63:0] addr_ext_2_q, addr_ext_2_d;
  logic        wen_2_q, wen_2_d;
  logic        ren_2_q, ren_2_d;
  logic [63:0] wdata_2_q, wdata_2_d;
  logic        busy_q, busy_d;
  logic        err_q, err_d;

  logic        rx_fire, tx_fire;
  logic [2:0]  last_idx;
  logic [15:0] step;
  logic [15:0] addr_masked;
  logic [15:0] addr_nxt;
  logic [63:0] buf_nxt;
  logic [2:0]  idx_nxt;

  assign rx_fire     = rx_valid & rx_ready_q;
  assign tx_fire     = tx_valid_q & tx_ready;
  assign last_idx    = is_d_q ? 3'd7 : 3'd3;
  assign step        = is_d_q ? 16'd8 : 16'd4;
  assign addr_masked = is_d_q ? {addr_q[15:3], 3'b000} : {addr_q[15:2], 2'b00};
  assign addr_nxt    = addr_q + step;
  assign idx_nxt     = byte_idx_q + 3'd1;

  always_comb begin
    state_d      = state_q;
    is_d_d       = is_d_q;
    is_rd_d      = is_rd_q;
    rej_d        = rej_q;
    addr_d       = addr_q;
    cnt_d        = cnt_q;
    byte_idx_d   = byte_idx_q;
    buf_d        = buf_q;
    wait_d       = wait_q;
    tx_data_d    = tx_data_q;
    tx_valid_d   = tx_valid_q;
    cpu_enable_d = cpu_enable_q;
    addr_ext_d   = addr_ext_q;
    addr_ext_2_d = addr_ext_2_q;
    wdata_d      = wdata_q;
    wdata_2_d    = wdata_2_q;
    err_d        = err_q;
    wen_d        = 1'b0;
    ren_d        = 1'b0;
    wen_2_d      = 1'b0;
    ren_2_d      = 1'b0;
    buf_nxt      = buf_q;

    unique case (state_q)
      StCmd: begin
        if (rx_fire) begin
          case (rx_data)
            CmdWrI, CmdWrD, CmdRdI, CmdRdD: begin
              is_d_d  = (rx_data == CmdWrD) || (rx_data == CmdRdD);
              is_rd_d = (rx_data == CmdRdI) || (rx_data == CmdRdD);
              // Memory commands while the core runs still consume the whole frame.
              rej_d   = cpu_enable_q;
              state_d = StAddrLo;
            end
            CmdRun: begin
              cpu_enable_d = 1'b1;
              err_d        = 1'b0;
              state_d      = StAck;
              tx_valid_d   = 1'b1;
              tx_data_d    = AckOk;
            end
            CmdHalt: begin
              cpu_enable_d = 1'b0;
              state_d      = StAck;
              tx_valid_d   = 1'b1;
              tx_data_d    = AckOk;
            end
            default: begin
              err_d      = 1'b1;
              state_d    = StAck;
              tx_valid_d = 1'b1;
              tx_data_d  = AckBad;
            end
          endcase
        end
      end
      StAddrLo: begin
        if (rx_fire) begin
          addr_d[7:0] = rx_data;
          state_d     = StAddrHi;
        end
      end
      StAddrHi: begin
        if (rx_fire) begin
          addr_d[15:8] = rx_data;
          state_d      = StCount;
        end
      end
      StCount: begin
        if (rx_fire) begin
          cnt_d      = (rx_data == 8'd0) ? 9'd256 : {1'b0, rx_data};
          addr_d     = addr_masked;
          byte_idx_d = 3'd0;
          if (!is_rd_q) begin
            state_d = StData;
          end else if (rej_q) begin
            err_d      = 1'b1;
            state_d    = StAck;
            tx_valid_d = 1'b1;
            tx_data_d  = AckBad;
          end else begin
            state_d = StRdReq;
            if (is_d_q) begin
              ren_2_d      = 1'b1;
              addr_ext_2_d = {48'd0, addr_masked};
            end else begin
              ren_d      = 1'b1;
              addr_ext_d = {48'd0, addr_masked};
            end
          end
        end
      end
      StData: begin
        if (rx_fire) begin
          buf_nxt[8*byte_idx_q +: 8] = rx_data;
          buf_d = buf_nxt;
          if (byte_idx_q == last_idx) begin
            byte_idx_d = 3'd0;
            state_d    = StWrite;
            if (!rej_q) begin
              if (is_d_q) begin
                wen_2_d      = 1'b1;
                addr_ext_2_d = {48'd0, addr_q};
                wdata_2_d    = buf_nxt;
              end else begin
                wen_d      = 1'b1;
                addr_ext_d = {48'd0, addr_q};
                wdata_d    = buf_nxt[31:0];
              end
            end
          end else begin
            byte_idx_d = idx_nxt;
          end
        end
      end
      StWrite: begin
        addr_d = addr_nxt;
        cnt_d  = cnt_q - 9'd1;
        if (cnt_q == 9'd1) begin
          if (rej_q) begin
            err_d = 1'b1;
          end
          state_d    = StAck;
          tx_valid_d = 1'b1;
          tx_data_d  = rej_q ? AckBad : AckOk;
        end else begin
          state_d = StData;
        end
      end
      StRdReq: begin
        wait_d  = WaitInit;
        state_d = StRdWait;
      end
      StRdWait: begin
        if (wait_q == 2'd0) begin
          buf_d      = is_d_q ? rdata_ext_2 : {32'd0, rdata_ext};
          tx_data_d  = is_d_q ? rdata_ext_2[7:0] : rdata_ext[7:0];
          tx_valid_d = 1'b1;
          byte_idx_d = 3'd0;
          state_d    = StRdSend;
        end else begin
          wait_d = wait_q - 2'd1;
        end
      end
      StRdSend: begin
        if (tx_fire) begin
          if (byte_idx_q == last_idx) begin
            addr_d     = addr_nxt;
            cnt_d      = cnt_q - 9'd1;
            byte_idx_d = 3'd0;
            if (cnt_q == 9'd1) begin
              state_d   = StAck;
              tx_data_d = AckOk;
            end else begin
              tx_valid_d = 1'b0;
              state_d    = StRdReq;
              if (is_d_q) begin
                ren_2_d      = 1'b1;
                addr_ext_2_d = {48'd0, addr_nxt};
              end else begin
                ren_d      = 1'b1;
                addr_ext_d = {48'd0, addr_nxt};
              end
            end
          end else begin
            byte_idx_d = idx_nxt;
            tx_data_d  = 8'(buf_q >> {idx_nxt, 3'b000});
          end
        end
      end
      StAck: begin
        if (tx_fire) begin
          tx_valid_d = 1'b0;
          state_d    = StCmd;
        end
      end
      default: state_d = StCmd;
    endcase

    // Handshake and status flags are registered from the upcoming state.
    rx_ready_d = (state_d == StCmd) || (state_d == StAddrLo) || (state_d == StAddrHi) ||
                 (state_d == StCount) || (state_d == StData);
    busy_d     = (state_d != StCmd);
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q      <= StCmd;
      is_d_q       <= 1'b0;
      is_rd_q      <= 1'b0;
      rej_q        <= 1'b0;
      addr_q       <= 16'd0;
      cnt_q        <= 9'd0;
      byte_idx_q   <= 3'd0;
      buf_q        <= 64'd0;
      wait_q       <= 2'd0;
      rx_ready_q   <= 1'b1;
      tx_data_q    <= 8'd0;
      tx_valid_q   <= 1'b0;
      cpu_enable_q <= 1'b0;
      addr_ext_q   <= 64'd0;
      wen_q        <= 1'b0;
      ren_q        <= 1'b0;
      wdata_q      <= 32'd0;
      addr_ext_2_q <= 64'd0;
      wen_2_q      <= 1'b0;
      ren_2_q      <= 1'b0;
      wdata_2_q    <= 64'd0;
      busy_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      is_d_q       <= is_d_d;
      is_rd_q      <= is_rd_d;
      rej_q        <= rej_d;
      addr_q       <= addr_d;
      cnt_q        <= cnt_d;
      byte_idx_q   <= byte_idx_d;
      buf_q        <= buf_d;
      wait_q       <= wait_d;
      rx_ready_q   <= rx_ready_d;
      tx_data_q    <= tx_data_d;
      tx_valid_q   <= tx_valid_d;
      cpu_enable_q <= cpu_enable_d;
      addr_ext_q   <= addr_ext_d;
      wen_q        <= wen_d;
      ren_q        <= ren_d;
      wdata_q      <= wdata_d;
      addr_ext_2_q <= addr_ext_2_d;
      wen_2_q      <= wen_2_d;
      ren_2_q      <= ren_2_d;
      wdata_2_q    <= wdata_2_d;
      busy_q       <= busy_d;
      err_q        <= err_d;
    end
  end

  assign rx_ready    = rx_ready_q;
  assign tx_data     = tx_data_q;
  assign tx_valid    = tx_valid_q;
  assign cpu_enable  = cpu_enable_q;
  assign addr_ext    = addr_ext_q;
  assign wen_ext     = wen_q;
  assign ren_ext     = ren_q;
  assign wdata_ext   = wdata_q;
  assign addr_ext_2  = addr_ext_2_q;
  assign wen_ext_2   = wen_2_q;
  assign ren_ext_2   = ren_2_q;
  assign wdata_ext_2 = wdata_2_q;
  assign busy        = busy_q;
  assign err         = err_q;

endmodule

// File: tb/tb_mem_loader.sv
// Directed bench for mem_loader: table of single-byte command frames plus hand-written
// write/read/stall/wrap/reset sequences against a simple memory model.
module tb_mem_loader;

  logic        clk = 1'b0;
  logic        arst_n = 1'b0;
  logic [7:0]  rx_data = 8'd0;
  logic        rx_valid = 1'b0;
  logic        rx_ready;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b0;
  logic        cpu_enable;
  logic [63:0] addr_ext;
  logic        wen_ext;
  logic        ren_ext;
  logic [31:0] wdata_ext;
  logic [31:0] rdata_ext = 32'd0;
  logic [63:0] addr_ext_2;
  logic        wen_ext_2;
  logic        ren_ext_2;
  logic [63:0] wdata_ext_2;
  logic [63:0] rdata_ext_2 = 64'd0;
  logic        busy;
  logic        err;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mem_loader #(.RD_LAT(1)) dut (
    .clk(clk), .arst_n(arst_n),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .cpu_enable(cpu_enable),
    .addr_ext(addr_ext), .wen_ext(wen_ext), .ren_ext(ren_ext),
    .wdata_ext(wdata_ext), .rdata_ext(rdata_ext),
    .addr_ext_2(addr_ext_2), .wen_ext_2(wen_ext_2), .ren_ext_2(ren_ext_2),
    .wdata_ext_2(wdata_ext_2), .rdata_ext_2(rdata_ext_2),
    .busy(busy), .err(err)
  );

  // Memory model with one cycle read latency.
  logic [31:0] imem [0:16383];
  logic [63:0] dmem [0:8191];
  always @(posedge clk) begin
    if (wen_ext)   imem[addr_ext[15:2]] <= wdata_ext;
    if (wen_ext_2) dmem[addr_ext_2[15:3]] <= wdata_ext_2;
    if (ren_ext)   rdata_ext <= imem[addr_ext[15:2]];
    if (ren_ext_2) rdata_ext_2 <= dmem[addr_ext_2[15:3]];
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  int cyc = 0;
  int last_acc = 0;
  int wen_cnt = 0, wen2_cnt = 0, ren_cnt = 0, ren2_cnt = 0;
  logic [15:0] wr_addr_q[$];
  logic [63:0] wr_data_q[$];
  int          wr_dly_q[$];

  always @(posedge clk) begin
    if (arst_n && rx_valid && rx_ready) last_acc = cyc;
    cyc = cyc + 1;
  end

  always @(negedge clk) begin
    if (arst_n) begin
      if (wen_ext) begin
        wen_cnt++;
        wr_addr_q.push_back(addr_ext[15:0]);
        wr_data_q.push_back({32'd0, wdata_ext});
        wr_dly_q.push_back(cyc - last_acc);
      end
      if (wen_ext_2) begin
        wen2_cnt++;
        wr_addr_q.push_back(addr_ext_2[15:0]);
        wr_data_q.push_back(wdata_ext_2);
        wr_dly_q.push_back(cyc - last_acc);
      end
      if (ren_ext)   ren_cnt++;
      if (ren_ext_2) ren2_cnt++;
      if (wen_ext || ren_ext || wen_ext_2 || ren_ext_2)
        chk("strobe_rules", {62'd0, (wen_ext | ren_ext) & (wen_ext_2 | ren_ext_2), cpu_enable},
            64'd0);
    end
  end

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    rx_data  = b;
    rx_valid = 1'b1;
    while (!rx_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!rx_ready) begin
      chk("rx_timeout", 64'd0, 64'd1);
      rx_valid = 1'b0;
      return;
    end
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic recv_byte(output logic [7:0] b);
    int n = 0;
    tx_ready = 1'b1;
    while (!tx_valid && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!tx_valid) begin
      chk("tx_timeout", 64'd0, 64'd1);
      b = 8'hXX;
      tx_ready = 1'b0;
      return;
    end
    b = tx_data;
    @(negedge clk);
    tx_ready = 1'b0;
  endtask

  task automatic send_hdr(input logic [7:0] cmd, input logic [15:0] a, input logic [7:0] n);
    send_byte(cmd);
    send_byte(a[7:0]);
    send_byte(a[15:8]);
    send_byte(n);
  endtask

  task automatic expect_rx(input string name, input logic [7:0] exp);
    logic [7:0] b;
    recv_byte(b);
    chk(name, {56'd0, b}, {56'd0, exp});
  endtask

  typedef struct {
    logic [7:0] cmd;
    logic [7:0] ack;
    logic       cpu;
    logic       err;
  } vec_t;

  vec_t vecs[8];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int w0, r0;
    logic [7:0] v, b;
    logic stable;
    logic [63:0] dword;

    vecs[0] = '{cmd: 8'h11, ack: 8'hA5, cpu: 1'b0, err: 1'b0};
    vecs[1] = '{cmd: 8'h55, ack: 8'hEE, cpu: 1'b0, err: 1'b1};
    vecs[2] = '{cmd: 8'h11, ack: 8'hA5, cpu: 1'b0, err: 1'b1};
    vecs[3] = '{cmd: 8'h10, ack: 8'hA5, cpu: 1'b1, err: 1'b0};
    vecs[4] = '{cmd: 8'h00, ack: 8'hEE, cpu: 1'b1, err: 1'b1};
    vecs[5] = '{cmd: 8'h10, ack: 8'hA5, cpu: 1'b1, err: 1'b0};
    vecs[6] = '{cmd: 8'hFF, ack: 8'hEE, cpu: 1'b1, err: 1'b1};
    vecs[7] = '{cmd: 8'h11, ack: 8'hA5, cpu: 1'b0, err: 1'b1};

    repeat (3) @(negedge clk);
    chk("rst_tx_valid", {63'd0, tx_valid}, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_cpu", {63'd0, cpu_enable}, 64'd0);
    chk("rst_err", {63'd0, err}, 64'd0);
    chk("rst_addr", addr_ext | addr_ext_2, 64'd0);
    chk("rst_wdata", {32'd0, wdata_ext} | wdata_ext_2, 64'd0);
    chk("rst_tx_data", {56'd0, tx_data}, 64'd0);
    arst_n = 1'b1;
    @(negedge clk);
    chk("rst_rx_ready", {63'd0, rx_ready}, 64'd1);

    // Single-byte command frames.
    for (int i = 0; i < 8; i++) begin
      send_byte(vecs[i].cmd);
      expect_rx($sformatf("vec%0d_ack", i), vecs[i].ack);
      chk($sformatf("vec%0d_cpu", i), {63'd0, cpu_enable}, {63'd0, vecs[i].cpu});
      chk($sformatf("vec%0d_err", i), {63'd0, err}, {63'd0, vecs[i].err});
    end

    // Two-word I-memory write; each strobe one cycle after its 4th byte.
    wr_addr_q.delete(); wr_data_q.delete(); wr_dly_q.delete();
    w0 = wen_cnt;
    send_byte(8'h01);
    chk("busy_mid_frame", {63'd0, busy}, 64'd1);
    send_byte(8'h10); send_byte(8'h00); send_byte(8'h02);
    send_byte(8'h13); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
    send_byte(8'h93); send_byte(8'h00); send_byte(8'h10); send_byte(8'h00);
    expect_rx("wri_ack", 8'hA5);
    chk("wri_pulses", 64'(wen_cnt - w0), 64'd2);
    if (wr_addr_q.size() == 2) begin
      chk("wri_addr0", {48'd0, wr_addr_q[0]}, 64'h10);
      chk("wri_data0", wr_data_q[0], 64'h13);
      chk("wri_dly0", 64'(wr_dly_q[0]), 64'd1);
      chk("wri_addr1", {48'd0, wr_addr_q[1]}, 64'h14);
      chk("wri_data1", wr_data_q[1], 64'h0010_0093);
      chk("wri_dly1", 64'(wr_dly_q[1]), 64'd1);
    end else begin
      chk("wri_log_size", 64'(wr_addr_q.size()), 64'd2);
    end

    // D-memory write then read back from an unaligned address.
    wr_addr_q.delete(); wr_data_q.delete(); wr_dly_q.delete();
    w0 = wen2_cnt;
    send_hdr(8'h02, 16'h0000, 8'h01);
    for (int i = 0; i < 8; i++) send_byte(8'(8'h11 * (i + 1)));
    expect_rx("wrd_ack", 8'hA5);
    chk("wrd_pulses", 64'(wen2_cnt - w0), 64'd1);
    if (wr_data_q.size() == 1) chk("wrd_data", wr_data_q[0], 64'h8877_6655_4433_2211);
    r0 = ren2_cnt;
    send_hdr(8'h04, 16'h0005, 8'h01);
    for (int i = 0; i < 8; i++) expect_rx($sformatf("rdd_b%0d", i), 8'(8'h11 * (i + 1)));
    expect_rx("rdd_ack", 8'hA5);
    chk("rdd_pulses", 64'(ren2_cnt - r0), 64'd1);

    // I-memory read of two words with a 10-cycle tx stall mid-word.
    r0 = ren_cnt;
    send_hdr(8'h03, 16'h0013, 8'h02);
    expect_rx("rdi_b0", 8'h13);
    @(negedge clk);
    v = tx_data;
    w0 = ren_cnt;
    stable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (!tx_valid || tx_data !== v) stable = 1'b0;
      @(negedge clk);
    end
    chk("stall_stable", {63'd0, stable}, 64'd1);
    chk("stall_no_ren", 64'(ren_cnt - w0), 64'd0);
    dword = 64'h0010_0093_0000_0013;
    for (int i = 1; i < 8; i++) expect_rx($sformatf("rdi_b%0d", i), 8'(dword >> (8 * i)));
    expect_rx("rdi_ack", 8'hA5);
    chk("rdi_pulses", 64'(ren_cnt - r0), 64'd2);

    // Address wrap at the top of the 16-bit space.
    wr_addr_q.delete(); wr_data_q.delete(); wr_dly_q.delete();
    send_hdr(8'h01, 16'hFFFC, 8'h02);
    for (int i = 0; i < 8; i++) send_byte(8'(i));
    expect_rx("wrap_ack", 8'hA5);
    if (wr_addr_q.size() == 2) begin
      chk("wrap_addr0", {48'd0, wr_addr_q[0]}, 64'hFFFC);
      chk("wrap_addr1", {48'd0, wr_addr_q[1]}, 64'h0000);
      chk("wrap_data1", wr_data_q[1], 64'h0706_0504);
    end else begin
      chk("wrap_log_size", 64'(wr_addr_q.size()), 64'd2);
    end

    // COUNT=0 means 256 words.
    wr_addr_q.delete(); wr_data_q.delete(); wr_dly_q.delete();
    w0 = wen_cnt;
    send_hdr(8'h01, 16'h1000, 8'h00);
    for (int i = 0; i < 1024; i++) send_byte(8'(i));
    expect_rx("c256_ack", 8'hA5);
    chk("c256_pulses", 64'(wen_cnt - w0), 64'd256);
    if (wr_addr_q.size() == 256) chk("c256_last_addr", {48'd0, wr_addr_q[255]}, 64'h13FC);

    // Memory commands are refused while the core runs.
    send_byte(8'h10);
    expect_rx("run_ack", 8'hA5);
    chk("run_cpu", {63'd0, cpu_enable}, 64'd1);
    w0 = wen_cnt;
    send_hdr(8'h01, 16'h0020, 8'h01);
    for (int i = 0; i < 4; i++) send_byte(8'hAA);
    expect_rx("rej_wr_ack", 8'hEE);
    chk("rej_wr_pulses", 64'(wen_cnt - w0), 64'd0);
    chk("rej_wr_err", {63'd0, err}, 64'd1);
    r0 = ren2_cnt;
    send_hdr(8'h04, 16'h0000, 8'h01);
    expect_rx("rej_rd_ack", 8'hEE);
    chk("rej_rd_pulses", 64'(ren2_cnt - r0), 64'd0);
    send_byte(8'h11);
    expect_rx("halt_ack", 8'hA5);
    chk("halt_cpu", {63'd0, cpu_enable}, 64'd0);
    chk("halt_err", {63'd0, err}, 64'd1);

    // Reset in the middle of a payload word.
    w0 = wen_cnt;
    send_hdr(8'h01, 16'h0040, 8'h01);
    send_byte(8'h01);
    send_byte(8'h02);
    arst_n = 1'b0;
    @(negedge clk);
    chk("mid_rst_busy", {63'd0, busy}, 64'd0);
    chk("mid_rst_err", {63'd0, err}, 64'd0);
    chk("mid_rst_addr", addr_ext, 64'd0);
    chk("mid_rst_wdata", {32'd0, wdata_ext}, 64'd0);
    repeat (2) @(negedge clk);
    arst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("mid_rst_no_wen", 64'(wen_cnt - w0), 64'd0);
    send_byte(8'h10);
    recv_byte(b);
    chk("post_rst_ack", {56'd0, b}, 64'hA5);
    chk("post_rst_cpu", {63'd0, cpu_enable}, 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_loader.md
MEM_LOADER -- requirements
Module: mem_loader

Interface
REQ-001 SHALL have parameter RD_LAT, default 1: cycles from ren_ext/ren_ext_2 pulse to valid rdata_ext/rdata_ext_2 (legal values 1..3).
REQ-002 SHALL have one clock and an asynchronous active-low reset, named clk and arst_n.
REQ-003 Ports:
- clk  in  1  rising-edge clock
- arst_n  in  1  asynchronous active-low reset
- rx_data  in  8  host command/payload byte
- rx_valid  in  1  rx_data valid
- rx_ready  out  1  loader accepts rx_data
- tx_data  out  8  response byte
- tx_valid  out  1  tx_data valid
- tx_ready  in  1  host accepts tx_data
- cpu_enable  out  1  drives the core's enable
- addr_ext  out  64  instruction-memory byte address
- wen_ext  out  1  instruction-memory write strobe
- ren_ext  out  1  instruction-memory read strobe
- wdata_ext  out  32  instruction-memory write word
- rdata_ext  in  32  instruction-memory read word
- addr_ext_2  out  64  data-memory byte address
- wen_ext_2  out  1  data-memory write strobe
- ren_ext_2  out  1  data-memory read strobe
- wdata_ext_2  out  64  data-memory write word
- rdata_ext_2  in  64  data-memory read word
- busy  out  1  high whenever the FSM is not in CMD
- err  out  1  sticky error flag

Function
REQ-004 Byte transfer on rx SHALL occur only when rx_valid and rx_ready are both high; on tx only when tx_valid and tx_ready are both high. Once tx_valid is high, it and tx_data SHALL hold until accepted.
REQ-005 Frame SHALL be: CMD, ADDR_LO, ADDR_HI, COUNT, then payload. COUNT gives words, with 0 meaning 256. RUN and HALT frames consist of CMD only.
REQ-006 Command codes: 0x01 WR_I, 0x02 WR_D, 0x03 RD_I, 0x04 RD_D, 0x10 RUN (cpu_enable<=1), 0x11 HALT (cpu_enable<=0).
REQ-007 FSM states SHALL be CMD, ADDR_LO, ADDR_HI, COUNT, DATA, WRITE, RD_REQ, RD_WAIT, RD_SEND, ACK.
REQ-008 rx_ready SHALL be high only in CMD, ADDR_LO, ADDR_HI, COUNT and DATA, and low in all other states.
REQ-009 The address SHALL be a 16-bit byte address, zero-extended to 64 bits on addr_ext/addr_ext_2. Low bits are masked: [1:0] for I-memory, [2:0] for D-memory.
REQ-010 After each word the address SHALL advance by 4 for I-memory and 8 for D-memory, wrapping modulo 2^16 (e.g. 0xFFFC+4 -> 0x0000).
REQ-011 Write payload bytes SHALL be packed little-endian: 4 bytes per word for I-memory, 8 bytes per word for D-memory.
REQ-012 Write timing: when the last byte of a word is accepted at cycle T, the FSM SHALL enter WRITE at T+1. wen_ext or wen_ext_2 SHALL be high for exactly that one cycle, with address and wdata stable. The FSM then returns to DATA, or goes to ACK after the final word.
REQ-013 Read timing: ren is high for one cycle in RD_REQ. RD_WAIT lasts RD_LAT cycles, and rdata is captured on its last cycle. RD_SEND then emits the word little-endian, 4 or 8 bytes. The next word's RD_REQ follows the last byte's acceptance; after the final word the FSM goes to ACK.
REQ-014 ACK SHALL emit a single byte: 0xA5 on success or 0xEE on error, then return to CMD.
REQ-015 An unknown CMD SHALL set err and go directly to ACK with 0xEE, consuming no further bytes.
REQ-016 WR_I, WR_D, RD_I and RD_D received while cpu_enable=1 SHALL consume the full frame (header and any write payload) but perform no memory access and return 0xEE with err set.
REQ-017 RUN and HALT SHALL update cpu_enable on the cycle after CMD acceptance and return 0xA5.
REQ-018 wen/ren strobes SHALL never be asserted for both memories in the same cycle, and never while cpu_enable=1.
REQ-019 err SHALL clear only on reset or on acceptance of a RUN command.
REQ-020 wdata_ext and wdata_ext_2 SHALL hold their last value between writes. All outputs SHALL be registered.

Reset
REQ-021 While arst_n=0, the block SHALL asynchronously force: state=CMD, cpu_enable=0, err=0, busy=0, tx_valid=0, rx_ready=1 after release, all strobes 0, addr_ext=addr_ext_2=0, wdata_ext=wdata_ext_2=0, tx_data=0.
REQ-022 Reset asserted mid-frame SHALL discard partial words with no strobe issued. The first byte accepted after release SHALL be treated as CMD.

Verification
REQ-023 WR_I 0x0010, COUNT=2, bytes 13 00 00 00 93 00 10 00 -> wen_ext pulses at addr 0x10 (wdata 0x00000013) and 0x14 (wdata 0x00100093), each pulse one cycle after its 4th byte; then tx byte 0xA5.
REQ-024 WR_D 0x0000 with 1 word, then RD_D 0x0000 COUNT=1, RD_LAT=1 -> ren_ext_2 pulses for one cycle; the 8 bytes echoed back equal the written bytes; then 0xA5.
REQ-025 RUN -> cpu_enable=1 and 0xA5. Then WR_I with 1 word -> no wen_ext pulse, 0xEE, err=1. Then HALT -> cpu_enable=0, err remains 1.
REQ-026 WR_I 0xFFFC, COUNT=2 -> writes at 0xFFFC then 0x0000. Separately, COUNT=0 -> exactly 256 wen_ext pulses.
REQ-027 CMD 0x55 -> 0xEE, err=1, next byte treated as CMD. Also: tx_ready held low for 10 cycles during RD_SEND -> tx_data and tx_valid stable throughout, no extra ren pulse.
REQ-028 Assert arst_n=0 after 2 of 4 payload bytes of WR_I -> no wen_ext pulse; after release, a RUN frame is decoded correctly and answered with 0xA5.
